// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads instruction memory combinationally and
// queues {instruction, pc} pairs in a 2-entry prefetch buffer. Optional macro: FETCH_STATS_EN.
module fetch_unit #(
  parameter int Width = 32,
  parameter int AddrW = 8,
  parameter int Depth = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [AddrW-1:0] A,
  input  logic [Width-1:0] RD,
  input  logic             redirect,
  input  logic [AddrW-1:0] redirect_pc,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [Width-1:0] inst,
  output logic [AddrW-1:0] inst_pc,
`ifdef FETCH_STATS_EN
  output logic [15:0]      fetch_count,
  output logic [15:0]      stall_count,
`endif
  output logic             fault
);

  typedef enum logic {RUN, FAULT} state_t;

  // One extra bit so Depth == 2**AddrW is representable and never trips the range check.
  localparam logic [AddrW:0] DepthLim = (AddrW+1)'(Depth);

  state_t           state;
  logic [AddrW-1:0] pc;
  logic [1:0]       count;
  logic [Width-1:0] data0, data1;
  logic [AddrW-1:0] pc0, pc1;
  logic             pop, push, in_range;

  assign A          = pc;
  assign inst_valid = (count != 2'd0);
  assign inst       = data0;
  assign inst_pc    = pc0;
  assign fault      = (state == FAULT);

  assign in_range = ({1'b0, pc} < DepthLim);
  assign pop      = inst_valid & inst_ready;
  assign push     = (state == RUN) & ~redirect & in_range & ((count != 2'd2) | pop);

  // NOTE: all sequential state uses non-blocking assignments so every register sees
  // pre-edge values; the two buffer entries are reset too because inst/inst_pc must read 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= RUN;
      pc    <= '0;
      count <= 2'd0;
      data0 <= '0;
      data1 <= '0;
      pc0   <= '0;
      pc1   <= '0;
    end else if (redirect) begin
      // A same-cycle pop has already been consumed by decode; everything else is dropped.
      state <= RUN;
      pc    <= redirect_pc;
      count <= 2'd0;
    end else begin
      if (state == RUN && !in_range)
        state <= FAULT;
      if (push)
        pc <= pc + 1'b1;
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            data0 <= RD;
            pc0   <= pc;
          end else begin
            data1 <= RD;
            pc1   <= pc;
          end
          count <= count + 1'b1;
        end
        2'b01: begin
          data0 <= data1;
          pc0   <= pc1;
          count <= count - 1'b1;
        end
        2'b11: begin
          if (count == 2'd2) begin
            data0 <= data1;
            pc0   <= pc1;
            data1 <= RD;
            pc1   <= pc;
          end else begin
            data0 <= RD;
            pc0   <= pc;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FETCH_STATS_EN
  // Statistics counters saturate and ignore redirects.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_count <= 16'd0;
      stall_count <= 16'd0;
    end else begin
      if (push && fetch_count != 16'hFFFF)
        fetch_count <= fetch_count + 16'd1;
      if (state == RUN && count == 2'd2 && !pop && stall_count != 16'hFFFF)
        stall_count <= stall_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a full-depth instance and a Depth=16 instance share stimulus;
// instruction memory word i holds 32'hE000_0000 + i.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect;
  logic [7:0]  redirect_pc;
  logic        inst_ready;

  logic [7:0]  a_m, a_s;
  logic [31:0] rd_m, rd_s;
  logic        valid_m, valid_s;
  logic [31:0] inst_m, inst_s;
  logic [7:0]  ipc_m, ipc_s;
  logic        fault_m, fault_s;
`ifdef FETCH_STATS_EN
  logic [15:0] fcnt_m, scnt_m, fcnt_s, scnt_s;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign rd_m = 32'hE000_0000 + {24'd0, a_m};
  assign rd_s = 32'hE000_0000 + {24'd0, a_s};

  fetch_unit #(.Width(32), .AddrW(8), .Depth(256)) dut_m (
    .clk(clk), .rst_n(rst_n), .A(a_m), .RD(rd_m),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .inst_valid(valid_m), .inst_ready(inst_ready), .inst(inst_m), .inst_pc(ipc_m),
`ifdef FETCH_STATS_EN
    .fetch_count(fcnt_m), .stall_count(scnt_m),
`endif
    .fault(fault_m)
  );

  fetch_unit #(.Width(32), .AddrW(8), .Depth(16)) dut_s (
    .clk(clk), .rst_n(rst_n), .A(a_s), .RD(rd_s),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .inst_valid(valid_s), .inst_ready(inst_ready), .inst(inst_s), .inst_pc(ipc_s),
`ifdef FETCH_STATS_EN
    .fetch_count(fcnt_s), .stall_count(scnt_s),
`endif
    .fault(fault_s)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; redirect = 1'b0; redirect_pc = 8'h00; inst_ready = 1'b1;
    #1;

    // Reset state and streaming at one instruction per cycle
    do_reset();
    check("rst_a", a_m, 0);
    check("rst_valid", valid_m, 0);
    check("rst_fault", fault_m, 0);
    check("rst_inst", inst_m, 0);
    check("rst_inst_pc", ipc_m, 0);
    step();
    for (int i = 0; i < 5; i++) begin
      check("stream_valid", valid_m, 1);
      check("stream_inst", inst_m, 64'hE000_0000 + 64'(i));
      check("stream_pc", ipc_m, 64'(i));
      step();
    end

    // Backpressure: buffer fills in two cycles, then PC holds
    inst_ready = 1'b0;
    do_reset();
    step(5);
    check("bp_a_hold", a_m, 2);
    check("bp_inst_hold", inst_m, 64'hE000_0000);
    check("bp_valid", valid_m, 1);
    inst_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("bp_release_valid", valid_m, 1);
      check("bp_release_pc", ipc_m, 64'(i));
      step();
    end

    // Redirect with a full buffer and a pop in the same cycle
    inst_ready = 1'b0;
    do_reset();
    step(3);
    inst_ready = 1'b1; redirect = 1'b1; redirect_pc = 8'h40;
    check("redir_popped_pc", ipc_m, 0);
    step();
    redirect = 1'b0;
    check("redir_a", a_m, 8'h40);
    check("redir_flushed", valid_m, 0);
    step();
    check("redir_valid", valid_m, 1);
    check("redir_inst_pc", ipc_m, 8'h40);
    check("redir_inst", inst_m, 64'hE000_0040);

    // Wrap-around on the full-depth instance
    redirect = 1'b1; redirect_pc = 8'hFE;
    step();
    redirect = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      check("wrap_pc", ipc_m, 64'((8'hFE + i) & 8'hFF));
      check("wrap_fault", fault_m, 0);
      step();
    end

    // Depth=16 instance: fault after address 16 is reached, redirect recovers
    do_reset();
    step(16);
    check("d16_last_pc", ipc_s, 15);
    check("d16_a16", a_s, 16);
    check("d16_no_fault_yet", fault_s, 0);
    step();
    check("d16_fault", fault_s, 1);
    check("d16_drained", valid_s, 0);
    step();
    check("d16_pc_hold", a_s, 16);
    redirect = 1'b1; redirect_pc = 8'h04;
    step();
    redirect = 1'b0;
    check("d16_fault_clr", fault_s, 0);
    check("d16_resume_a", a_s, 4);
    step();
    check("d16_resume_pc", ipc_s, 4);
    check("d16_resume_valid", valid_s, 1);

    // Mid-stream reset overrides a simultaneous redirect
    step(3);
    rst_n = 1'b0; redirect = 1'b1; redirect_pc = 8'h33;
    step();
    rst_n = 1'b1; redirect = 1'b0;
    check("mrst_valid", valid_m, 0);
    check("mrst_a", a_m, 0);
    check("mrst_fault", fault_m, 0);
    check("mrst_a_s", a_s, 0);
`ifdef FETCH_STATS_EN
    check("mrst_fetch_count", fcnt_m, 0);
    check("mrst_stall_count", scnt_m, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
